// File: rtl/uart_rx_pkg.sv
// uart_defs: shared types and helpers for the UART receive path.
//   RXState_t  receiver FSM state encoding
//   RX_FIFO_W  receive FIFO entry width: {parity error, data[7:0]}
//   maj3       2-of-3 majority vote, used when UART_RX_MAJORITY_EN is defined
//   par8       XOR reduction of a data byte (even-parity helper)
package uart_defs;

    localparam int RX_FIFO_W = 9;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } RXState_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic par8(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO for received bytes.
// The head entry is visible on o_head whenever o_empty is low; a pop advances
// the read pointer at the clock edge. Flush clears the FIFO and wins over a
// same-cycle push.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_push       write i_push_data (ignored when full unless popping this cycle)
//   i_pop        remove head entry (ignored when empty)
//   i_flush      empty the FIFO
//   o_head       head-of-FIFO entry
//   o_count      number of stored entries (0..DEPTH)
//   o_full       count == DEPTH
//   o_empty      count == 0
module uart_rx_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);

    // Storage array write; no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART frame receiver (1 start, 8 data LSB first, even parity, 1 stop).
// The line is synchronized, deframed by a tick-driven FSM and the byte plus its
// parity error flag is pushed into a small FWFT FIFO.
// Optional feature macro: UART_RX_MAJORITY_EN -- each bit is decided by a 2-of-3
// vote over the ticks around the sample point instead of a single sample.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tick_i          one-clk enable at OVERSAMPLE x baud
//   rx_i            asynchronous serial input, idle high
//   rx_enable_i     permits starting a new frame
//   rx_rts_n_o      ready-to-receive toward far end, active low
//   rx_d_o          head-of-FIFO data byte
//   rx_perr_o       parity error flag of the head entry
//   rx_d_valid_o    FIFO non-empty
//   rx_d_ready_i    consumer pop request
//   rx_full_o       FIFO full
//   rx_empty_o      FIFO empty
//   frame_err_o     one-clk pulse on a bad stop bit
//   overrun_o       one-clk pulse when a received byte is dropped (FIFO full)
//   flush_i         clears the FIFO
module uart_rx
    import uart_defs::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic       rx_i,
    input  logic       rx_enable_i,
    output logic       rx_rts_n_o,
    output logic [7:0] rx_d_o,
    output logic       rx_perr_o,
    output logic       rx_d_valid_o,
    input  logic       rx_d_ready_i,
    output logic       rx_full_o,
    output logic       rx_empty_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       flush_i
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // With majority voting the decision moves one tick later (c+1); since every
    // later bit is timed from this decision, all bits shift consistently.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] START_PT = TW'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [TW-1:0] START_PT = TW'(OVERSAMPLE / 2);
`endif
    localparam logic [TW-1:0] BIT_END = TW'(OVERSAMPLE - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rxs;
    logic                 w_sample;

    RXState_t             r_state;
    logic [TW-1:0]        r_tcnt;
    logic [2:0]           r_bcnt;
    logic [7:0]           r_data;
    logic                 r_perr;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_rts_n;

    logic                 w_push;
    logic [RX_FIFO_W-1:0] w_push_data;
    logic                 w_pop;
    logic [RX_FIFO_W-1:0] w_head;
    logic [CW-1:0]        w_count;
    logic                 w_full;
    logic                 w_empty;

    // Two-flop synchronizer for the asynchronous line, idle (1) out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    // r_win[0] holds the line one tick ago, r_win[1] two ticks ago.
    logic [1:0] r_win;

    // Sliding window of the last two tick samples for the 2-of-3 vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= 2'b11;
        end else if (tick_i) begin
            r_win <= {r_win[0], w_rxs};
        end
    end

    assign w_sample = maj3(r_win[1], r_win[0], w_rxs);
`else
    assign w_sample = w_rxs;
`endif

    // Frame deframing FSM; advances only on ticks, error pulse lasts one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_tcnt      <= '0;
            r_bcnt      <= 3'd0;
            r_data      <= 8'h00;
            r_perr      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (tick_i) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!w_rxs && rx_enable_i) begin
                            r_state <= RX_START;
                            r_tcnt  <= '0;
                        end
                    end
                    RX_START: begin
                        if (r_tcnt == START_PT) begin
                            r_tcnt <= '0;
                            if (w_sample) begin
                                r_state <= RX_IDLE;
                            end else begin
                                r_state <= RX_DATA;
                                r_bcnt  <= 3'd0;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (r_tcnt == BIT_END) begin
                            r_tcnt         <= '0;
                            r_data[r_bcnt] <= w_sample;
                            if (r_bcnt == 3'd7) begin
                                r_state <= RX_PARITY;
                            end else begin
                                r_bcnt <= r_bcnt + 3'd1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                    RX_PARITY: begin
                        if (r_tcnt == BIT_END) begin
                            r_tcnt  <= '0;
                            r_perr  <= w_sample ^ par8(r_data);
                            r_state <= RX_STOP;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (r_tcnt == BIT_END) begin
                            r_tcnt <= '0;
                            if (w_sample) begin
                                r_state <= RX_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= RX_WAIT_IDLE;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                    RX_WAIT_IDLE: begin
                        if (w_rxs) begin
                            r_state <= RX_IDLE;
                        end
                    end
                    default: begin
                        r_state <= RX_IDLE;
                        r_tcnt  <= '0;
                    end
                endcase
            end
        end
    end

    // Push at the mid-stop-bit decision so a back-to-back start edge is not missed.
    assign w_push      = tick_i && (r_state == RX_STOP) && (r_tcnt == BIT_END) && w_sample;
    assign w_push_data = {r_perr, r_data};
    assign w_pop       = !w_empty && rx_d_ready_i;

    uart_rx_fifo #(
        .WIDTH (RX_FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (flush_i),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Overrun pulse and RTS; RTS drops early to leave room for a frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_rts_n   <= 1'b1;
        end else begin
            r_overrun <= w_push && w_full && !w_pop && !flush_i;
            r_rts_n   <= !(rx_enable_i && (w_count < CW'(FIFO_DEPTH - 1)));
        end
    end

    assign rx_d_o       = w_empty ? 8'h00 : w_head[7:0];
    assign rx_perr_o    = w_empty ? 1'b0  : w_head[8];
    assign rx_d_valid_o = !w_empty;
    assign rx_empty_o   = w_empty;
    assign rx_full_o    = w_full;
    assign rx_rts_n_o   = r_rts_n;
    assign frame_err_o  = r_frame_err;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are generated bit by bit
// from their definition (start, data LSB first, parity, stop) and the expected
// FIFO contents, error and overrun counts come from a queue-based model.
module tb_uart_rx;

    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       tick_i;
    logic       rx_i;
    logic       rx_enable_i;
    logic       rx_rts_n_o;
    logic [7:0] rx_d_o;
    logic       rx_perr_o;
    logic       rx_d_valid_o;
    logic       rx_d_ready_i;
    logic       rx_full_o;
    logic       rx_empty_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       flush_i;

    int n_checks = 0;
    int n_errors = 0;
    int fe_seen  = 0;
    int ov_seen  = 0;
    int fe_exp   = 0;
    int ov_exp   = 0;
    logic [8:0] q[$];

    uart_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_i       (tick_i),
        .rx_i         (rx_i),
        .rx_enable_i  (rx_enable_i),
        .rx_rts_n_o   (rx_rts_n_o),
        .rx_d_o       (rx_d_o),
        .rx_perr_o    (rx_perr_o),
        .rx_d_valid_o (rx_d_valid_o),
        .rx_d_ready_i (rx_d_ready_i),
        .rx_full_o    (rx_full_o),
        .rx_empty_o   (rx_empty_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .flush_i      (flush_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick is high every other clock cycle.
    initial begin
        tick_i = 1'b0;
        forever begin
            @(negedge clk);
            tick_i = ~tick_i;
        end
    end

    // Count error pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_err_o) fe_seen++;
        if (overrun_o)   ov_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        int g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (!tick_i && g < 8);
        #1;
    endtask

    task automatic hold(input logic b, input int n);
        rx_i = b;
        for (int k = 0; k < n; k++) wait_tick();
    endtask

    // Sends one frame; gbit/gtick select an optional one-tick inverted glitch.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input int gbit, input int gtick);
        logic [10:0] bits;
        bits = {sbit, pbit, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            for (int t = 0; t < OS; t++) begin
                rx_i = (b == gbit && t == gtick) ? ~bits[b] : bits[b];
                wait_tick();
            end
        end
        rx_i = 1'b1;
    endtask

    // Applies the model's push rule for a frame with a good stop bit.
    task automatic model_push(input logic [7:0] d, input logic pbit);
        if (q.size() < DEPTH) q.push_back({pbit ^ (^d), d});
        else ov_exp++;
    endtask

    task automatic drain();
        logic [8:0] e;
        int guard = 0;
        while (q.size() > 0 && guard < DEPTH + 2) begin
            @(negedge clk);
            e = q.pop_front();
            check_eq("drain_valid", 32'(rx_d_valid_o), 32'd1);
            check_eq("drain_data", 32'(rx_d_o), 32'(e[7:0]));
            check_eq("drain_perr", 32'(rx_perr_o), 32'(e[8]));
            rx_d_ready_i = 1'b1;
            @(posedge clk);
            #1 rx_d_ready_i = 1'b0;
            guard++;
        end
        @(negedge clk);
        check_eq("drain_empty", 32'(rx_empty_o), 32'd1);
        check_eq("drain_model_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       inj;
        logic       bad;

        rst = 1'b1; rx_i = 1'b1; rx_enable_i = 1'b0; rx_d_ready_i = 1'b0; flush_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rts_n", 32'(rx_rts_n_o), 32'd1);
        check_eq("rst_valid", 32'(rx_d_valid_o), 32'd0);
        check_eq("rst_empty", 32'(rx_empty_o), 32'd1);
        check_eq("rst_full", 32'(rx_full_o), 32'd0);
        check_eq("rst_ferr", 32'(frame_err_o), 32'd0);
        check_eq("rst_ovr", 32'(overrun_o), 32'd0);
        check_eq("rst_perr", 32'(rx_perr_o), 32'd0);
        check_eq("rst_data", 32'(rx_d_o), 32'd0);
        #1 rst = 1'b0; rx_enable_i = 1'b1;
        hold(1'b1, 2 * OS);
        check_eq("rts_enabled", 32'(rx_rts_n_o), 32'd0);

        // Clean byte
        send_frame(8'hA5, 1'b0, 1'b1, -1, 0); model_push(8'hA5, 1'b0);
        hold(1'b1, 4);
        check_eq("clean_valid", 32'(rx_d_valid_o), 32'd1);
        drain();

        // Parity error
        send_frame(8'h01, 1'b0, 1'b1, -1, 0); model_push(8'h01, 1'b0);
        hold(1'b1, 4);
        drain();

        // False start
        hold(1'b0, 4);
        hold(1'b1, 3 * OS);
        check_eq("false_start_empty", 32'(rx_d_valid_o), 32'd0);

        // Frame error with long break, then a good byte
        send_frame(8'h3C, ^8'h3C, 1'b0, -1, 0); fe_exp++;
        hold(1'b0, 20 * OS);
        hold(1'b1, 2 * OS);
        check_eq("ferr_count", 32'(fe_seen), 32'(fe_exp));
        check_eq("ferr_no_push", 32'(rx_d_valid_o), 32'd0);
        send_frame(8'h55, ^8'h55, 1'b1, -1, 0); model_push(8'h55, ^8'h55);
        hold(1'b1, 4);
        drain();

        // Overrun and RTS with the consumer stalled, frames back to back
        for (int i = 0; i < 5; i++) begin
            d = 8'h10 + 8'(i);
            send_frame(d, ^d, 1'b1, -1, 0); model_push(d, ^d);
            @(negedge clk);
            if (i < 3) check_eq("rts_after_frame", 32'(rx_rts_n_o), 32'(q.size() >= DEPTH - 1));
        end
        hold(1'b1, 4);
        check_eq("ovr_full", 32'(rx_full_o), 32'd1);
        check_eq("ovr_count", 32'(ov_seen), 32'(ov_exp));
        drain();

        // Flush discards stored bytes
        send_frame(8'h77, ^8'h77, 1'b1, -1, 0);
        hold(1'b1, 4);
        flush_i = 1'b1; @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        check_eq("flush_empty", 32'(rx_empty_o), 32'd1);

        // Randomized frames against the model
        for (int i = 0; i < 16; i++) begin
            d   = 8'($urandom);
            inj = ($urandom_range(0, 3) == 0);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(d, (^d) ^ inj, ~bad, -1, 0);
            if (bad) begin
                fe_exp++;
                hold(1'b0, 2 * OS);
                hold(1'b1, 2 * OS);
            end else begin
                model_push(d, (^d) ^ inj);
                hold(1'b1, $urandom_range(1, OS));
            end
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        check_eq("rand_ferr_count", 32'(fe_seen), 32'(fe_exp));
        check_eq("rand_ovr_count", 32'(ov_seen), 32'(ov_exp));

        // Reset during data bit 4 with one entry already stored
        send_frame(8'h5A, ^8'h5A, 1'b1, -1, 0);
        hold(1'b1, OS);
        d = 8'hC3;
        hold(1'b0, OS);
        for (int b = 0; b < 4; b++) hold(d[b], OS);
        hold(d[4], OS / 2);
        rst = 1'b1; rx_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_valid", 32'(rx_d_valid_o), 32'd0);
        check_eq("midrst_rts_n", 32'(rx_rts_n_o), 32'd1);
        check_eq("midrst_data", 32'(rx_d_o), 32'd0);
        #1 rst = 1'b0;
        hold(1'b1, 2 * OS);
        send_frame(8'hFF, ^8'hFF, 1'b1, -1, 0); model_push(8'hFF, ^8'hFF);
        hold(1'b1, 4);
        drain();

`ifdef UART_RX_MAJORITY_EN
        // One-tick glitches near the middle of a data bit are voted out
        for (int g = 7; g < 11; g++) begin
            send_frame(8'h96, ^8'h96, 1'b1, 4, g); model_push(8'h96, ^8'h96);
            hold(1'b1, 4);
            drain();
        end
`endif

        check_eq("final_ferr_count", 32'(fe_seen), 32'(fe_exp));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
